// File: rtl/coin_acceptor.sv
// Coin acceptor: per-sensor debouncers, a 4-deep coin FIFO and an output FSM that drives
// each queued coin code for HOLD cycles followed by GAP idle cycles.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned HOLD     = 1,
  parameter int unsigned GAP      = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       nickel_in,
  input  logic       dime_in,
  input  logic       quarter_in,
  input  logic       accept_en,
  output logic [1:0] coin,
  output logic       coin_reject,
  output logic [2:0] fifo_count
);

  typedef enum logic [1:0] {DbLow, DbRise, DbHigh, DbFall} db_state_e;
  typedef enum logic [1:0] {OutIdle, OutDrive, OutGap} out_state_e;

  localparam logic [4:0] DbLen   = 5'(DEBOUNCE);
  localparam logic [2:0] HoldLen = 3'(HOLD);
  localparam logic [2:0] GapLen  = 3'(GAP);

  db_state_e  db_q     [3];
  logic [3:0] db_cnt_q [3];
  logic [2:0] sensor;
  logic [2:0] settled;
  logic [2:0] high_side;
  logic [2:0] qual;

  logic [1:0] fifo_mem_q [4];
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;

  out_state_e out_q;
  logic [2:0] out_cnt_q;

  logic [1:0] qual_code;
  logic       jam;
  logic       single;
  logic       multi;
  logic       full;
  logic       empty;
  logic       pop;
  logic       push;
  logic       reject;

  assign sensor = {quarter_in, dime_in, nickel_in};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      // Counter is cleared in LOW/HIGH, so the entry cycle alone settles when DEBOUNCE is 1.
      settled[i]   = ({1'b0, db_cnt_q[i]} + 5'd1) >= DbLen;
      high_side[i] = (db_q[i] == DbHigh) || (db_q[i] == DbFall);
      qual[i]      = sensor[i] && settled[i] && ((db_q[i] == DbLow) || (db_q[i] == DbRise));
    end
  end

  always_comb begin
    qual_code = 2'd0;
    jam       = 1'b0;
    case (qual)
      3'b001: begin
        qual_code = 2'd1;
        jam       = high_side[1] | high_side[2];
      end
      3'b010: begin
        qual_code = 2'd2;
        jam       = high_side[0] | high_side[2];
      end
      3'b100: begin
        qual_code = 2'd3;
        jam       = high_side[0] | high_side[1];
      end
      default: ;
    endcase
    single = (qual_code != 2'd0);
    multi  = (qual != 3'b000) && !single;
    full   = (fifo_count == 3'd4);
    empty  = (fifo_count == 3'd0);
    // The end of GAP passes through IDLE in the same cycle, so back-to-back coins see GAP zeros.
    pop    = !empty && accept_en &&
             ((out_q == OutIdle) || ((out_q == OutGap) && (out_cnt_q >= GapLen)));
    push   = single && !jam && (!full || pop);
    reject = multi || (single && !push);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        db_q[i]     <= DbLow;
        db_cnt_q[i] <= 4'd0;
      end
      for (int j = 0; j < 4; j++) begin
        fifo_mem_q[j] <= 2'd0;
      end
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      fifo_count  <= 3'd0;
      out_q       <= OutIdle;
      out_cnt_q   <= 3'd0;
      coin        <= 2'd0;
      coin_reject <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        case (db_q[i])
          DbLow, DbRise: begin
            if (!sensor[i]) begin
              db_q[i]     <= DbLow;
              db_cnt_q[i] <= 4'd0;
            end else if (settled[i]) begin
              db_q[i]     <= DbHigh;
              db_cnt_q[i] <= 4'd0;
            end else begin
              db_q[i]     <= DbRise;
              db_cnt_q[i] <= (db_cnt_q[i] == 4'hF) ? db_cnt_q[i] : db_cnt_q[i] + 4'd1;
            end
          end
          default: begin
            if (sensor[i]) begin
              db_q[i]     <= DbHigh;
              db_cnt_q[i] <= 4'd0;
            end else if (settled[i]) begin
              db_q[i]     <= DbLow;
              db_cnt_q[i] <= 4'd0;
            end else begin
              db_q[i]     <= DbFall;
              db_cnt_q[i] <= (db_cnt_q[i] == 4'hF) ? db_cnt_q[i] : db_cnt_q[i] + 4'd1;
            end
          end
        endcase
      end

      if (push) begin
        fifo_mem_q[wr_ptr_q] <= qual_code;
        wr_ptr_q             <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 3'd1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 3'd1;
      end
      coin_reject <= reject;

      case (out_q)
        OutIdle: begin
          if (pop) begin
            out_q     <= OutDrive;
            out_cnt_q <= 3'd1;
            coin      <= fifo_mem_q[rd_ptr_q];
          end
        end
        OutDrive: begin
          if (out_cnt_q >= HoldLen) begin
            out_q     <= OutGap;
            out_cnt_q <= 3'd1;
            coin      <= 2'd0;
          end else begin
            out_cnt_q <= out_cnt_q + 3'd1;
          end
        end
        OutGap: begin
          if (pop) begin
            out_q     <= OutDrive;
            out_cnt_q <= 3'd1;
            coin      <= fifo_mem_q[rd_ptr_q];
          end else if (out_cnt_q >= GapLen) begin
            out_q     <= OutIdle;
            out_cnt_q <= 3'd0;
          end else begin
            out_cnt_q <= out_cnt_q + 3'd1;
          end
        end
        default: begin
          out_q     <= OutIdle;
          out_cnt_q <= 3'd0;
          coin      <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus random sensor traffic, all
// compared against a level/run-length and slot-countdown reference model.
module tb_coin_acceptor;

  localparam int unsigned DEBOUNCE = 3;
  localparam int unsigned HOLD     = 1;
  localparam int unsigned GAP      = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       nickel_in;
  logic       dime_in;
  logic       quarter_in;
  logic       accept_en;
  logic [1:0] coin;
  logic       coin_reject;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;

  coin_acceptor #(
    .DEBOUNCE(DEBOUNCE),
    .HOLD    (HOLD),
    .GAP     (GAP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .nickel_in  (nickel_in),
    .dime_in    (dime_in),
    .quarter_in (quarter_in),
    .accept_en  (accept_en),
    .coin       (coin),
    .coin_reject(coin_reject),
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  // Reference model: a qualified level per sensor flips after DEBOUNCE consecutive disagreeing
  // samples; the output is a slot of HOLD+GAP cycles counted down after each pop.
  bit       m_lvl [3];
  int       m_dis [3];
  bit [1:0] m_q [$];
  int       m_ph;
  bit [1:0] m_cur;
  bit [1:0] exp_coin;
  bit       exp_rej;

  task automatic model_edge(input bit r, input bit [2:0] s, input bit a);
    bit       old_lvl [3];
    bit [2:0] ql;
    bit       pop;
    bit       jam;
    bit       push;
    bit       rej;
    int       k;
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        m_lvl[i] = 1'b0;
        m_dis[i] = 0;
      end
      m_q.delete();
      m_ph     = 0;
      m_cur    = 2'd0;
      exp_coin = 2'd0;
      exp_rej  = 1'b0;
      return;
    end
    ql = 3'b000;
    k  = 0;
    for (int i = 0; i < 3; i++) begin
      old_lvl[i] = m_lvl[i];
      if (s[i] != m_lvl[i]) begin
        m_dis[i]++;
        if (m_dis[i] >= DEBOUNCE) begin
          m_lvl[i] = s[i];
          m_dis[i] = 0;
          ql[i]    = s[i];
        end
      end else begin
        m_dis[i] = 0;
      end
    end
    pop  = (m_ph <= 1) && (m_q.size() > 0) && a;
    push = 1'b0;
    rej  = 1'b0;
    if ($countones(ql) > 1) begin
      rej = 1'b1;
    end else if (ql != 3'b000) begin
      k   = ql[0] ? 0 : (ql[1] ? 1 : 2);
      jam = 1'b0;
      for (int j = 0; j < 3; j++) if (j != k && old_lvl[j]) jam = 1'b1;
      if (jam || (m_q.size() == 4 && !pop)) rej = 1'b1;
      else push = 1'b1;
    end
    if (pop) begin
      m_cur = m_q.pop_front();
      m_ph  = HOLD + GAP;
    end else if (m_ph > 0) begin
      m_ph--;
    end
    if (push) m_q.push_back(2'(k + 1));
    exp_rej  = rej;
    exp_coin = (m_ph > GAP) ? m_cur : 2'd0;
  endtask

  // s is {quarter, dime, nickel}.
  task automatic step(input bit r, input bit [2:0] s, input bit a);
    reset = r;
    {quarter_in, dime_in, nickel_in} = s;
    accept_en = a;
    @(posedge clock);
    model_edge(r, s, a);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 3'b111, 1'b1);
    step(1'b1, 3'b010, 1'b0);
    checks++;
    if ({coin, coin_reject, fifo_count} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state coin/rej/cnt=%0d/%0d/%0d expected 0/0/0",
               coin, coin_reject, fifo_count);
    end
    // Dime held high through reset release must wait a full window.
    for (int i = 1; i <= DEBOUNCE + 1; i++) begin
      step(1'b0, 3'b010, 1'b0);
      checks++;
      if (fifo_count !== ((i >= DEBOUNCE) ? 3'd1 : 3'd0)) begin
        errors++;
        $display("FAIL reset_release cycle%0d fifo_count=%0d expected %0d",
                 i, fifo_count, (i >= DEBOUNCE) ? 1 : 0);
      end
    end
  endtask

  task automatic test_single_dime();
    int n_dime = 0;
    int t_push = -1;
    int t_coin = -1;
    step(1'b1, 3'b000, 1'b1);
    for (int c = 0; c < 14; c++) begin
      step(1'b0, (c < 5) ? 3'b010 : 3'b000, 1'b1);
      checks++;
      if ({coin, coin_reject, fifo_count} !== {exp_coin, exp_rej, 3'(m_q.size())}) begin
        errors++;
        $display("FAIL dime cycle%0d coin/rej/cnt=%0d/%0d/%0d expected %0d/%0d/%0d",
                 c, coin, coin_reject, fifo_count, exp_coin, exp_rej, m_q.size());
      end
      if (coin == 2'd2) n_dime++;
      if (coin == 2'd2 && t_coin < 0) t_coin = c;
      if (fifo_count == 3'd1 && t_push < 0) t_push = c;
    end
    checks++;
    if (n_dime != HOLD) begin
      errors++;
      $display("FAIL dime_hold cycles=%0d expected %0d", n_dime, HOLD);
    end
    checks++;
    if (t_push < 0 || t_coin - t_push != 1) begin
      errors++;
      $display("FAIL dime_latency push@%0d coin@%0d expected coin one cycle after push",
               t_push, t_coin);
    end
  endtask

  task automatic test_glitch();
    int seen = 0;
    step(1'b1, 3'b000, 1'b1);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, (c < 2) ? 3'b001 : 3'b000, 1'b1);
      checks++;
      if ({coin, coin_reject, fifo_count} !== {exp_coin, exp_rej, 3'(m_q.size())}) begin
        errors++;
        $display("FAIL glitch cycle%0d coin/rej/cnt=%0d/%0d/%0d expected %0d/%0d/%0d",
                 c, coin, coin_reject, fifo_count, exp_coin, exp_rej, m_q.size());
      end
      if (coin != 2'd0 || coin_reject || fifo_count != 3'd0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL glitch_quiet active_cycles=%0d expected 0", seen);
    end
  endtask

  task automatic test_fifo_full();
    int       n_rej   = 0;
    int       max_cnt = 0;
    bit [1:0] pat [10] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
    step(1'b1, 3'b000, 1'b0);
    for (int c = 0; c < 40; c++) begin
      step(1'b0, (c % 8 < 4) ? 3'b001 : 3'b000, 1'b0);
      checks++;
      if ({coin, coin_reject, fifo_count} !== {exp_coin, exp_rej, 3'(m_q.size())}) begin
        errors++;
        $display("FAIL fill cycle%0d coin/rej/cnt=%0d/%0d/%0d expected %0d/%0d/%0d",
                 c, coin, coin_reject, fifo_count, exp_coin, exp_rej, m_q.size());
      end
      if (coin_reject) n_rej++;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end
    checks++;
    if (n_rej != 1 || max_cnt != 4) begin
      errors++;
      $display("FAIL fill_overflow rejects=%0d max_count=%0d expected 1 and 4", n_rej, max_cnt);
    end
    for (int c = 0; c < 14; c++) begin
      step(1'b0, 3'b000, 1'b1);
      checks++;
      if ({coin, coin_reject, fifo_count} !== {exp_coin, exp_rej, 3'(m_q.size())}) begin
        errors++;
        $display("FAIL drain cycle%0d coin/rej/cnt=%0d/%0d/%0d expected %0d/%0d/%0d",
                 c, coin, coin_reject, fifo_count, exp_coin, exp_rej, m_q.size());
      end
      if (c < 10) begin
        checks++;
        if (coin !== pat[c]) begin
          errors++;
          $display("FAIL drain_pattern cycle%0d coin=%0d expected %0d", c, coin, pat[c]);
        end
      end
    end
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL drain_empty fifo_count=%0d expected 0", fifo_count);
    end
  endtask

  task automatic test_simultaneous();
    int n_rej = 0;
    int busy  = 0;
    step(1'b1, 3'b000, 1'b1);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, (c < 4) ? 3'b110 : 3'b000, 1'b1);
      checks++;
      if ({coin, coin_reject, fifo_count} !== {exp_coin, exp_rej, 3'(m_q.size())}) begin
        errors++;
        $display("FAIL simul cycle%0d coin/rej/cnt=%0d/%0d/%0d expected %0d/%0d/%0d",
                 c, coin, coin_reject, fifo_count, exp_coin, exp_rej, m_q.size());
      end
      if (coin_reject) n_rej++;
      if (coin != 2'd0 || fifo_count != 3'd0) busy++;
    end
    checks++;
    if (n_rej != 1 || busy != 0) begin
      errors++;
      $display("FAIL simul_reject rejects=%0d busy_cycles=%0d expected 1 and 0", n_rej, busy);
    end
  endtask

  task automatic test_reset_mid_drive();
    bit [2:0] seq [3] = '{3'b010, 3'b100, 3'b001};
    bit       found   = 1'b0;
    int       late    = 0;
    step(1'b1, 3'b000, 1'b0);
    for (int n = 0; n < 3; n++) begin
      for (int c = 0; c < 7; c++) begin
        step(1'b0, (c < 3) ? seq[n] : 3'b000, 1'b0);
        checks++;
        if ({coin, coin_reject, fifo_count} !== {exp_coin, exp_rej, 3'(m_q.size())}) begin
          errors++;
          $display("FAIL queue3 coin%0d cycle%0d coin/rej/cnt=%0d/%0d/%0d expected %0d/%0d/%0d",
                   n, c, coin, coin_reject, fifo_count, exp_coin, exp_rej, m_q.size());
        end
      end
    end
    checks++;
    if (fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL queue3_count fifo_count=%0d expected 3", fifo_count);
    end
    for (int c = 0; c < 10 && !found; c++) begin
      step(1'b0, 3'b000, 1'b1);
      if (coin == 2'd2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_drive_start coin never reached 2 within 10 cycles");
    end
    step(1'b1, 3'b000, 1'b1);
    checks++;
    if (coin !== 2'd0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL mid_drive_reset coin/cnt=%0d/%0d expected 0/0", coin, fifo_count);
    end
    for (int c = 0; c < 15; c++) begin
      step(1'b0, 3'b000, 1'b1);
      if (coin != 2'd0 || fifo_count != 3'd0) late++;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL mid_drive_after active_cycles=%0d expected 0", late);
    end
  endtask

  task automatic test_random();
    bit [2:0] s = 3'b000;
    bit       a = 1'b1;
    bit       r;
    step(1'b1, 3'b000, 1'b1);
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 5) == 0) s[i] = ~s[i];
      if ($urandom_range(0, 11) == 0) a = ~a;
      r = ($urandom_range(0, 299) == 0);
      step(r, s, a);
      checks++;
      if ({coin, coin_reject, fifo_count} !== {exp_coin, exp_rej, 3'(m_q.size())}) begin
        errors++;
        $display("FAIL random cycle%0d coin/rej/cnt=%0d/%0d/%0d expected %0d/%0d/%0d",
                 c, coin, coin_reject, fifo_count, exp_coin, exp_rej, m_q.size());
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    nickel_in  = 1'b0;
    dime_in    = 1'b0;
    quarter_in = 1'b0;
    accept_en  = 1'b0;
    test_reset();
    test_single_dime();
    test_glitch();
    test_fifo_full();
    test_simultaneous();
    test_reset_mid_drive();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
